i2c_target_stream: RTL and testbench

- Generic I2C target (responder) PHY; counterpart to the controller-side I2C initiator.
- Decodes START/STOP, matches a 7-bit address, and ACKs.
- Written bytes leave on a valid/ready stream; read bytes are pulled from a valid/ready stream.
- Sits between the open-drain pad pair and any byte-oriented backend (register file, EEPROM model, FIFO); stretches SCL while the backend is not ready.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_line_sync.sv | 56 +++++
 rtl/i2c_target_stream.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_target_stream.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target stream block.
package i2c_pkg;

   localparam int   I2C_ADDR_W = 7;
   localparam logic I2C_ACK    = 1'b0;
   localparam logic I2C_NACK   = 1'b1;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_LOAD,
      RD_DATA,
      RD_ACK,
      SKIP
   } i2c_target_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with bus-event detection (SCL edges, START, STOP).
// Events are masked until the synchronizer chain has refilled after reset,
// so a reset taken mid-transfer cannot fabricate a START or STOP from the
// reset value of the flops.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_raw,
   input  logic sda_raw,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   localparam int WARM   = SYNC_STAGES + 1;
   localparam int WARM_W = $clog2(WARM + 1);

   logic [SYNC_STAGES-1:0] scl_ff;
   logic [SYNC_STAGES-1:0] sda_ff;
   logic                   scl_q;
   logic                   sda_q;
   logic [WARM_W-1:0]      warm;
   logic                   armed;
   logic                   scl;

   assign scl   = scl_ff[SYNC_STAGES-1];
   assign sda   = sda_ff[SYNC_STAGES-1];
   assign armed = (warm == WARM_W'(WARM));

   // Shift the raw lines through the sync chain and keep one cycle of history.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_ff <= '1;
         sda_ff <= '1;
         scl_q  <= 1'b1;
         sda_q  <= 1'b1;
         warm   <= '0;
      end else begin
         scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_raw};
         sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_raw};
         scl_q  <= scl;
         sda_q  <= sda;
         if (!armed) warm <= warm + WARM_W'(1);
      end
   end

   assign scl_rise = armed &  scl & ~scl_q;
   assign scl_fall = armed & ~scl &  scl_q;
   assign start    = armed &  scl &  scl_q &  sda_q & ~sda;
   assign stop     = armed &  scl &  scl_q & ~sda_q &  sda;

endmodule

// File: rtl/i2c_target_stream.sv
// I2C target PHY: address match + ACK, write bytes out on an rx stream,
// read bytes pulled from a tx stream.
// Build option I2C_TARGET_STRETCH_EN: when defined the target stretches SCL
// while the backend is not ready; otherwise scl_oe stays 0, a write byte
// that finds the rx slot busy is NACKed and dropped, and a read with no
// tx data sends 8'hFF. Both fallbacks pulse overrun.
module i2c_target_stream
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] I2C_ADDR    = 7'h50,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   output logic       scl_o,
   output logic       scl_oe,
   input  logic       sda_i,
   output logic       sda_o,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_first,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       txn_start,
   output logic       txn_read,
   output logic       txn_stop,
   output logic       overrun,
   output logic       busy
);

`ifdef I2C_TARGET_STRETCH_EN
   localparam logic STRETCH = 1'b1;
`else
   localparam logic STRETCH = 1'b0;
`endif

   i2c_target_state_t state;
   logic [3:0]        cnt;
   logic [7:0]        sh;
   logic              hold;
   logic              first_pend;
   logic              sda;
   logic              scl_rise;
   logic              scl_fall;
   logic              start;
   logic              stop;
   logic              free;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .scl_raw  (scl_i),
      .sda_raw  (sda_i),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   assign scl_o = ~scl_oe;
   assign sda_o = ~sda_oe;
   assign free  = ~rx_valid | rx_ready;

   // Bus protocol FSM; all outputs registered. START/STOP override every state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sh         <= '0;
         hold       <= 1'b0;
         first_pend <= 1'b0;
         scl_oe     <= 1'b0;
         sda_oe     <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_first   <= 1'b0;
         tx_ready   <= 1'b0;
         txn_start  <= 1'b0;
         txn_read   <= 1'b0;
         txn_stop   <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         txn_start <= 1'b0;
         txn_stop  <= 1'b0;
         overrun   <= 1'b0;
         // rx handshake completes regardless of bus events; a load below wins
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
         end
         if (start) begin
            state    <= ADDR;
            cnt      <= '0;
            hold     <= 1'b0;
            sda_oe   <= 1'b0;
            scl_oe   <= 1'b0;
            tx_ready <= 1'b0;
         end else if (stop) begin
            state    <= IDLE;
            cnt      <= '0;
            hold     <= 1'b0;
            sda_oe   <= 1'b0;
            scl_oe   <= 1'b0;
            tx_ready <= 1'b0;
            if (busy) begin
               txn_stop <= 1'b1;
               busy     <= 1'b0;
            end
         end else begin
            case (state)
               IDLE, SKIP: ;
               ADDR: begin
                  if (scl_rise && cnt != 4'd8) begin
                     sh  <= {sh[6:0], sda};
                     cnt <= cnt + 4'd1;
                  end else if (scl_fall && cnt == 4'd8) begin
                     if (sh[7:1] == I2C_ADDR) begin
                        sda_oe    <= 1'b1;
                        txn_start <= 1'b1;
                        txn_read  <= sh[0];
                        busy      <= 1'b1;
                        state     <= ADDR_ACK;
                     end else begin
                        state <= SKIP;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     cnt    <= '0;
                     if (txn_read) begin
                        tx_ready <= 1'b1;
                        scl_oe   <= STRETCH;
                        state    <= RD_LOAD;
                     end else begin
                        first_pend <= 1'b1;
                        state      <= WR_DATA;
                     end
                  end
               end
               WR_DATA: begin
                  if (scl_rise && cnt != 4'd8) begin
                     sh  <= {sh[6:0], sda};
                     cnt <= cnt + 4'd1;
                  end else if (cnt == 4'd8 && (scl_fall || hold)) begin
                     if (free) begin
                        rx_data    <= sh;
                        rx_valid   <= 1'b1;
                        rx_first   <= first_pend;
                        first_pend <= 1'b0;
                        sda_oe     <= 1'b1;
                        scl_oe     <= 1'b0;
                        hold       <= 1'b0;
                        state      <= WR_ACK;
                     end else begin
`ifdef I2C_TARGET_STRETCH_EN
                        scl_oe <= 1'b1;
                        hold   <= 1'b1;
`else
                        overrun <= 1'b1;
                        state   <= SKIP;
`endif
                     end
                  end
               end
               WR_ACK: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     cnt    <= '0;
                     state  <= WR_DATA;
                  end
               end
               RD_LOAD: begin
                  if (tx_ready && tx_valid) begin
                     sh       <= tx_data;
                     sda_oe   <= ~tx_data[7];
                     cnt      <= 4'd1;
                     tx_ready <= 1'b0;
                     scl_oe   <= 1'b0;
                     state    <= RD_DATA;
                  end else begin
`ifdef I2C_TARGET_STRETCH_EN
                     scl_oe <= 1'b1;
`else
                     // underflow: send all-ones (SDA released) for this byte
                     sh       <= 8'hFF;
                     sda_oe   <= 1'b0;
                     cnt      <= 4'd1;
                     tx_ready <= 1'b0;
                     overrun  <= 1'b1;
                     state    <= RD_DATA;
`endif
                  end
               end
               RD_DATA: begin
                  if (scl_fall) begin
                     if (cnt == 4'd8) begin
                        sda_oe <= 1'b0;
                        state  <= RD_ACK;
                     end else begin
                        sda_oe <= ~sh[6];
                        sh     <= {sh[6:0], 1'b1};
                        cnt    <= cnt + 4'd1;
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_rise) begin
                     if (sda != I2C_ACK) state <= SKIP;
                  end else if (scl_fall) begin
                     tx_ready <= 1'b1;
                     scl_oe   <= STRETCH;
                     state    <= RD_LOAD;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_stream.sv
// Bench for i2c_target_stream: bit-banged I2C controller on a wired-AND bus,
// rx/tx stream models and queue-based scoreboards.
module tb_i2c_target_stream;
   import i2c_pkg::*;

   localparam int T = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       scl_line, sda_line;
   logic       scl_o, scl_oe, sda_o, sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid, rx_first;
   logic       rx_ready = 1'b1;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       txn_start, txn_read, txn_stop, overrun, busy;

   int n_cmp = 0;
   int n_err = 0;
   int rx_got = 0, rx_exp_total = 0;
   int starts = 0, stops = 0, ovr = 0, tx_hs = 0, od_bad = 0;
   logic sda_any = 1'b0;

   logic [8:0] rx_q[$];
   logic       txn_q[$];
   logic [7:0] tx_q[$];

   assign scl_line = m_scl & ~scl_oe;
   assign sda_line = m_sda & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target_stream dut (
      .clk(clk), .rst(rst),
      .scl_i(scl_line), .scl_o(scl_o), .scl_oe(scl_oe),
      .sda_i(sda_line), .sda_o(sda_o), .sda_oe(sda_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_first(rx_first),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .txn_start(txn_start), .txn_read(txn_read), .txn_stop(txn_stop),
      .overrun(overrun), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // release SCL and wait (bounded) for the line to go high
   task automatic scl_up();
      int n = 0;
      m_scl = 1'b1;
      do begin
         @(posedge clk); #1; n++;
      end while (scl_line !== 1'b1 && n < 2000);
      if (n >= 2000) chk("scl_stuck", 32'(scl_line), 32'd1);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; cyc(T);
      scl_up(); cyc(T);
      m_sda = 1'b0; cyc(T);
      m_scl = 1'b0; cyc(T);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; cyc(T);
      scl_up(); cyc(T);
      m_sda = 1'b1; cyc(T);
   endtask

   task automatic bit_xfer(input logic b, output logic r);
      m_sda = b; cyc(T);
      scl_up(); cyc(T/2);
      @(negedge clk); r = sda_line;
      cyc(T/2);
      m_scl = 1'b0; cyc(T);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
      bit_xfer(1'b1, ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         d[i] = r;
      end
      bit_xfer(nack, r);
   endtask

   // tx stream source: head of tx_q is offered; popped after each handshake
   initial begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (tx_valid && tx_ready) begin
            tx_hs++;
            @(posedge clk); #1;
            if (tx_q.size() != 0) void'(tx_q.pop_front());
         end
         tx_valid = (tx_q.size() != 0);
         if (tx_valid) tx_data = tx_q[0];
         else          tx_data = 8'h00;
      end
   end

   // output monitors: rx scoreboard, transaction scoreboard, event counters
   initial begin
      logic [8:0] e9;
      logic       e1;
      forever begin
         @(negedge clk);
         if (rx_valid && rx_ready) begin
            rx_got++;
            if (rx_q.size() != 0) begin
               e9 = rx_q.pop_front();
               chk("rx_byte", {23'd0, rx_first, rx_data}, {23'd0, e9});
            end
         end
         if (txn_start) begin
            starts++;
            if (txn_q.size() != 0) begin
               e1 = txn_q.pop_front();
               chk("txn_read", 32'(txn_read), 32'(e1));
            end
         end
         if (txn_stop) stops++;
         if (overrun)  ovr++;
         if (sda_oe)   sda_any = 1'b1;
         if (scl_o !== ~scl_oe || sda_o !== ~sda_oe) od_bad++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack;
      logic [7:0] d;
      logic       r;
      int         sb, eb, ob, hb, held;

      // reset state
      cyc(4);
      @(negedge clk);
      chk("rst_lines", {scl_o, sda_o, scl_oe, sda_oe}, 4'b1100);
      chk("rst_rx",    {rx_valid, rx_first, rx_data}, 10'd0);
      chk("rst_misc",  {tx_ready, txn_start, txn_read, txn_stop, overrun, busy}, 6'd0);
      cyc(1); rst = 1'b0; cyc(4);

      // 1: plain write of two bytes
      sb = stops;
      txn_q.push_back(1'b0);
      i2c_start();
      write_byte(8'hA0, ack); chk("w_addr_ack", ack, I2C_ACK);
      chk("w_busy", busy, 1'b1);
      rx_q.push_back({1'b1, 8'hA5}); rx_exp_total++;
      write_byte(8'hA5, ack); chk("w_d0_ack", ack, I2C_ACK);
      rx_q.push_back({1'b0, 8'h3C}); rx_exp_total++;
      write_byte(8'h3C, ack); chk("w_d1_ack", ack, I2C_ACK);
      i2c_stop(); cyc(4);
      chk("w_stop", stops - sb, 1);
      chk("w_idle_busy", busy, 1'b0);

      // 2: wrong address is ignored
      sda_any = 1'b0; sb = starts;
      i2c_start();
      write_byte(8'hA2, ack); chk("na_addr", ack, I2C_NACK);
      write_byte(8'h12, ack); chk("na_data", ack, I2C_NACK);
      chk("na_state", 32'(dut.state), 32'(SKIP));
      i2c_stop(); cyc(4);
      chk("na_sda", sda_any, 1'b0);
      chk("na_start", starts - sb, 0);

      // 3: read two bytes, ACK then NACK
      sb = stops; hb = tx_hs;
      tx_q.push_back(8'h55); tx_q.push_back(8'hAA);
      txn_q.push_back(1'b1);
      i2c_start();
      write_byte(8'hA1, ack); chk("r_addr_ack", ack, I2C_ACK);
      read_byte(1'b0, d); chk("r_b0", d, 8'h55);
      read_byte(1'b1, d); chk("r_b1", d, 8'hAA);
      chk("r_sda_rel", sda_oe, 1'b0);
      i2c_stop(); cyc(4);
      chk("r_tx_hs", tx_hs - hb, 2);
      chk("r_stop", stops - sb, 1);

      // 4: backend stalls on the second write byte
      ob = ovr;
      rx_ready = 1'b0;
      txn_q.push_back(1'b0);
      i2c_start();
      write_byte(8'hA0, ack); chk("s_addr_ack", ack, I2C_ACK);
      rx_q.push_back({1'b1, 8'h11}); rx_exp_total++;
      write_byte(8'h11, ack); chk("s_d0_ack", ack, I2C_ACK);
`ifdef I2C_TARGET_STRETCH_EN
      rx_q.push_back({1'b0, 8'h22}); rx_exp_total++;
      held = 0;
      fork
         write_byte(8'h22, ack);
         begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!scl_oe && n < 600);
            repeat (50) begin
               @(negedge clk);
               if (scl_oe) held++;
            end
            @(posedge clk); #1;
            rx_ready = 1'b1;
         end
      join
      chk("s_stretch", held, 50);
      chk("s_d1_ack", ack, I2C_ACK);
      chk("s_ovr", ovr - ob, 0);
`else
      write_byte(8'h22, ack);
      chk("s_d1_nack", ack, I2C_NACK);
      chk("s_ovr", ovr - ob, 1);
      cyc(50);
      rx_ready = 1'b1;
`endif
      i2c_stop(); cyc(4);

      // 5: write then repeated START into a read
      tx_q.push_back(8'h96);
      txn_q.push_back(1'b0); txn_q.push_back(1'b1);
      sb = stops; eb = starts;
      i2c_start();
      write_byte(8'hA0, ack); chk("rs_w_ack", ack, I2C_ACK);
      rx_q.push_back({1'b1, 8'h07}); rx_exp_total++;
      write_byte(8'h07, ack); chk("rs_d_ack", ack, I2C_ACK);
      i2c_start();
      write_byte(8'hA1, ack); chk("rs_r_ack", ack, I2C_ACK);
      chk("rs_nostop", stops - sb, 0);
      chk("rs_starts", starts - eb, 2);
      read_byte(1'b1, d); chk("rs_rd", d, 8'h96);
      i2c_stop(); cyc(4);
      chk("rs_stop", stops - sb, 1);

      // 6: reset during bit 4 of a read byte (0xC3: bit 4 is a driven 0)
      tx_q.push_back(8'hC3);
      txn_q.push_back(1'b1);
      i2c_start();
      write_byte(8'hA1, ack); chk("rr_addr_ack", ack, I2C_ACK);
      for (int i = 0; i < 3; i++) bit_xfer(1'b1, r);
      m_sda = 1'b1; cyc(T);
      scl_up(); cyc(2);
      chk("rr_pre_sda", sda_oe, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rr_oe", {scl_oe, sda_oe}, 2'b00);
      chk("rr_busy", busy, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      sda_any = 1'b0; sb = stops; eb = starts;
      cyc(T); m_scl = 1'b0; cyc(T);
      for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
      bit_xfer(1'b0, r);
      i2c_stop(); cyc(4);
      chk("rr_quiet", sda_any, 1'b0);
      chk("rr_nostart", starts - eb, 0);
      chk("rr_nostop", stops - sb, 0);
      // target answers again after a fresh START
      txn_q.push_back(1'b0);
      i2c_start();
      write_byte(8'hA0, ack); chk("rr_new_ack", ack, I2C_ACK);
      rx_q.push_back({1'b1, 8'h5A}); rx_exp_total++;
      write_byte(8'h5A, ack); chk("rr_new_d", ack, I2C_ACK);
      i2c_stop(); cyc(8);

      chk("rx_count", rx_got, rx_exp_total);
      chk("rx_left",  rx_q.size(), 0);
      chk("txn_left", txn_q.size(), 0);
      chk("open_drain", od_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
